// File: rtl/exa_if.sv
// exa_if: parameter write port and sample stream of the exa FIR stage.
interface exa_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int MEM_WIDTH  = 32,
    parameter int IN_WIDTH   = 24,
    parameter int OUT_WIDTH  = 24
);
    logic                  WrEn_SI;
    logic [ADDR_WIDTH-1:0] Addr_DI;
    logic [MEM_WIDTH-1:0]  PAR_In_DI;
    logic [IN_WIDTH-1:0]   EXA_In_DI;
    logic [OUT_WIDTH-1:0]  EXA_Out_DO;
    modport master (output WrEn_SI, Addr_DI, PAR_In_DI, EXA_In_DI, input EXA_Out_DO);
    modport slave  (input WrEn_SI, Addr_DI, PAR_In_DI, EXA_In_DI, output EXA_Out_DO);
endinterface

// File: rtl/exa.sv
// exa: 4-tap FIR with register-file coefficients, arithmetic shift, offset and saturation.
module exa #(
    parameter int ADDR_WIDTH = 5,
    parameter int MEM_WIDTH  = 32,
    parameter int IN_WIDTH   = 24,
    parameter int OUT_WIDTH  = 24
) (
    input logic Clk_CI,
    input logic Rst_RBI,
    exa_if.slave bus
);
    localparam int AW = IN_WIDTH + 18;
    localparam int TW = IN_WIDTH + 19;
    localparam logic signed [TW-1:0] HI = {{(TW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [TW-1:0] LO = ~HI;

    logic [MEM_WIDTH-1:0]        mem [2**ADDR_WIDTH];
    logic signed [IN_WIDTH-1:0]  x   [4];
    logic signed [IN_WIDTH+15:0] p   [4];
    logic signed [AW-1:0]        acc;
    logic signed [AW-1:0]        sh;
    logic signed [TW-1:0]        t;
    logic [OUT_WIDTH-1:0]        y;
    logic                        unused;

    always_ff @(posedge Clk_CI) begin
        if (Rst_RBI) begin
            for (int i = 0; i < 2**ADDR_WIDTH; i++) mem[i] <= '0;
            for (int i = 0; i < 4; i++) begin
                x[i] <= '0;
                p[i] <= '0;
            end
            bus.EXA_Out_DO <= '0;
        end else begin
            if (bus.WrEn_SI) mem[bus.Addr_DI] <= bus.PAR_In_DI;
            x[0] <= bus.EXA_In_DI;
            for (int i = 1; i < 4; i++) x[i] <= x[i-1];
            for (int i = 0; i < 4; i++) p[i] <= x[i] * $signed(mem[i][15:0]);
            bus.EXA_Out_DO <= y;
        end
    end

    // acc is wide enough that the four-product sum never overflows
    always_comb begin
        acc = AW'(p[0]) + AW'(p[1]) + AW'(p[2]) + AW'(p[3]);
        sh  = acc >>> mem[4][4:0];
        t   = TW'(sh) + TW'($signed(mem[5][IN_WIDTH-1:0]));
        y   = t > HI ? HI[OUT_WIDTH-1:0] : t < LO ? LO[OUT_WIDTH-1:0] : t[OUT_WIDTH-1:0];
    end

    always_comb begin
        unused = 1'b0;
        for (int i = 0; i < 2**ADDR_WIDTH; i++) unused = unused ^ (^mem[i]);
    end
endmodule

// File: tb/tb_exa.sv
// tb_exa: directed and random stimulus for exa checked against an edge-indexed reference model.
module tb_exa;
    localparam int N = 4096;
    localparam int OMAX = 8388607;
    localparam int OMIN = -8388608;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    exa_if bus ();
    exa dut (.Clk_CI(clk), .Rst_RBI(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] mem_m [32];
    int in_at  [N];
    int coef_at[N][4];
    int s_at   [N];
    int off_at [N];
    int e = 0;
    int last_rst = -1;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output after edge e: samples taken at edge e-2-k weighted by the coefficient in memory before
    // edge e-1, shifted and offset by S/OFF in memory before edge e; any reset since the sample voids it.
    function automatic int model_out();
        longint acc = 0;
        longint t;
        for (int k = 0; k < 4; k++) begin
            int j = e - 2 - k;
            if (j >= 0 && j > last_rst) acc += longint'(in_at[j]) * longint'(coef_at[e-1][k]);
        end
        t = (acc >>> s_at[e]) + longint'(off_at[e]);
        return t > OMAX ? OMAX : t < OMIN ? OMIN : int'(t);
    endfunction

    task automatic cyc(input logic r, input logic we, input int a, input logic [31:0] d,
                       input int x, output int got);
        int exp;
        rst           = r;
        bus.WrEn_SI   = we;
        bus.Addr_DI   = 5'(a);
        bus.PAR_In_DI = d;
        bus.EXA_In_DI = 24'(x);
        @(posedge clk);
        for (int k = 0; k < 4; k++) coef_at[e][k] = int'($signed(mem_m[k][15:0]));
        s_at[e]   = int'(mem_m[4][4:0]);
        off_at[e] = int'($signed(mem_m[5][23:0]));
        in_at[e]  = x;
        if (r) begin
            last_rst = e;
            for (int i = 0; i < 32; i++) mem_m[i] = '0;
        end else if (we) mem_m[a] = d;
        exp = r ? 0 : model_out();
        e++;
        @(negedge clk);
        got = int'($signed(bus.EXA_Out_DO));
        check("model", got, exp);
    endtask

    task automatic idle(input int x, output int got);
        cyc(1'b0, 1'b0, 0, 32'd0, x, got);
    endtask

    task automatic wr(input int a, input logic [31:0] d, output int got);
        cyc(1'b0, 1'b1, a, d, 0, got);
    endtask

    initial begin
        int got;
        logic [23:0] rnd;
        // reset with a concurrent write request and nonzero input
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b1, 0, 32'd5, 1000, got);
            check("reset_out", got, 0);
        end
        for (int i = 0; i < 5; i++) begin
            idle(1000, got);
            check("post_reset_zero", got, 0);
        end
        // impulse response
        for (int k = 0; k < 4; k++) wr(k, 32'(k + 1), got);
        wr(4, 32'd0, got);
        wr(5, 32'd0, got);
        for (int i = 0; i < 4; i++) idle(0, got);
        idle(10, got);
        for (int i = 1; i <= 7; i++) begin
            idle(0, got);
            check("impulse", got, (i >= 2 && i <= 5) ? 10 * (i - 1) : 0);
        end
        // reset one cycle after an impulse
        idle(10, got);
        cyc(1'b1, 1'b0, 0, 32'd0, 0, got);
        check("midreset", got, 0);
        for (int i = 0; i < 6; i++) begin
            idle(0, got);
            check("midreset_tail", got, 0);
        end
        idle(10, got);
        for (int i = 0; i < 6; i++) begin
            idle(0, got);
            check("params_cleared", got, 0);
        end
        // shift truncates toward minus infinity
        wr(0, 32'd3, got);
        wr(4, 32'd1, got);
        idle(-5, got);
        idle(0, got);
        idle(0, got);
        check("shift_trunc", got, -8);
        // saturation both ways
        wr(0, 32'h7FFF, got);
        wr(4, 32'd0, got);
        idle(OMAX, got);
        idle(0, got);
        idle(0, got);
        check("sat_hi", got, OMAX);
        idle(OMIN, got);
        idle(0, got);
        idle(0, got);
        check("sat_lo", got, OMIN);
        // offset then coefficient write timing
        cyc(1'b1, 1'b0, 0, 32'd0, 0, got);
        wr(5, 32'hFFFF_FF9C, got);
        idle(0, got);
        check("offset_k1", got, -100);
        for (int i = 0; i < 3; i++) idle(50, got);
        cyc(1'b0, 1'b1, 0, 32'd1, 50, got);
        check("coef_m0", got, -100);
        idle(50, got);
        check("coef_m1", got, -100);
        idle(50, got);
        check("coef_m2", got, -50);
        // random traffic
        for (int i = 0; i < 1500; i++) begin
            logic r, we;
            int a, x;
            logic [31:0] d;
            r   = ($urandom % 100) == 0;
            we  = ($urandom % 6) == 0;
            a   = $urandom % 8;
            d   = $urandom;
            if (a == 4) d = $urandom % 20;
            rnd = 24'($urandom);
            x   = ($urandom % 2) ? int'($signed(rnd)) : int'($urandom % 2001) - 1000;
            cyc(r, we, a, d, x, got);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
